uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 2, giving the number of clk cycles per serial bit; legal values are 1 to 65535.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port data_in, input, 8 bits: parallel byte to transmit.
REQ-005 The module SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-006 The module SHALL have port data_ready, output, 1 bit: the holding register can accept a byte this cycle.
REQ-007 The module SHALL have port busy, output, 1 bit: a frame is in progress (state not IDLE).
REQ-008 The module SHALL have port tx, output, 1 bit: registered serial line that drives the receiver input; idle level is high.

Function
REQ-009 Frame format SHALL be: start bit (0), 8 data bits LSB first, 1 parity bit, stop bit (1), for 11 bits in total.
REQ-010 The parity bit SHALL be odd parity, equal to ~(^byte), so that the count of ones over data plus parity is odd.
REQ-011 Each bit SHALL hold on tx for exactly CLKS_PER_BIT clk cycles, timed by an internal bit-period counter that wraps to 0 at CLKS_PER_BIT-1.
REQ-012 A byte SHALL be accepted on a rising edge where data_valid=1 and data_ready=1; it is stored in a one-entry holding register and hold_full is set.
REQ-013 data_ready SHALL equal !hold_full && !rst (combinational).
REQ-014 When data_valid=1 and data_ready=0, the byte SHALL be ignored, with no change to the holding register.
REQ-015 The state machine SHALL have exactly five states: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
REQ-016 IDLE: tx=1; on any edge with hold_full=1, the FSM SHALL load the shifter from the holding register, clear hold_full, latch parity, clear the bit counters, set tx=0, and go to START_BIT.
REQ-017 Latency from the acceptance edge to tx=0 SHALL be exactly 1 clk edge when the FSM is in IDLE.
REQ-018 START_BIT: after CLKS_PER_BIT cycles the FSM SHALL drive tx = data bit 0 and go to DATA_BITS.
REQ-019 DATA_BITS: the FSM SHALL shift out one bit per bit period using a 3-bit index 0..7; after bit 7's period it SHALL drive the parity bit and go to PARITY_BIT.
REQ-020 PARITY_BIT: after one bit period the FSM SHALL drive tx=1 and go to STOP_BIT.
REQ-021 STOP_BIT end: if hold_full=1, the FSM SHALL reload the shifter as in REQ-016 and go directly to START_BIT with no idle gap; otherwise it SHALL go to IDLE with tx=1.
REQ-022 A byte SHALL be acceptable while a frame is shifting; data_ready returns to 1 on the edge where the holding register transfers to the shifter.
REQ-023 If acceptance and a transfer occur on the same edge, it is not possible (ready=0 while full); the holding register SHALL never be overwritten while full.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Frame length SHALL be exactly 11*CLKS_PER_BIT clk cycles; back-to-back frames SHALL have period 11*CLKS_PER_BIT.
REQ-026 Illegal state encodings SHALL return to IDLE on the next edge with tx=1.

Reset
REQ-027 While rst=1 on an edge: state=IDLE, tx=1, busy=0, hold_full=0, bit counters=0, and data_ready=0.
REQ-028 rst asserted mid-frame SHALL abort the frame immediately (tx=1 on the next edge); the holding byte SHALL be discarded, and no partial frame SHALL resume after rst deasserts.
REQ-029 On the first cycle after rst deasserts, data_ready SHALL be 1.

Verification
REQ-030 CLKS_PER_BIT=2, send 0x55 from idle -> tx=0 one edge later; tx sequence 0,1,0,1,0,1,0,1,0,1(parity),1, each held 2 cycles; busy=1 for 22 cycles.
REQ-031 Send 0x00 -> parity bit=1; send 0x07 -> data bits 1,1,1,0,0,0,0,0 and parity bit=0.
REQ-032 Send 0xA3 and then 0x3C accepted during the first frame -> second start bit begins the cycle after the first stop bit ends, with no idle high cycles; data_ready=0 from the 0x3C acceptance until reload.
REQ-033 With hold full, present a third byte 0xFF with data_valid=1 -> it is ignored; only 0xA3 and 0x3C appear on tx.
REQ-034 Assert rst for 1 cycle during DATA_BITS of 0x81 -> tx=1 and busy=0 from the next edge; the line stays high with no further frame.
REQ-035 Loopback: tx into the receiver stage (clocked at the same bit rate) with CLKS_PER_BIT=2 and 256 bytes 0x00..0xFF -> every byte is received intact, with no parity error and a valid stop bit.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8O1 UART transmitter: start bit, 8 data bits LSB first, odd parity, stop bit.
// A one-entry holding register lets the next byte queue up while a frame shifts out.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       busy,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic        tx_q;
    logic        busy_q;
    logic        hold_full_q;
    logic        parity_q;
    logic [7:0]  hold_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] clk_cnt_q;

    logic period_end;
    logic reload;
    logic accept;

    // Reload happens from IDLE immediately, or at the end of a stop bit for
    // gapless back-to-back frames; hold_full blocks acceptance on those edges.
    always_comb begin
        period_end = (clk_cnt_q == CNT_MAX);
        reload     = hold_full_q && ((state_q == IDLE) ||
                                     ((state_q == STOP_BIT) && period_end));
        accept     = data_valid && data_ready;
    end

    assign data_ready = !hold_full_q && !rst;
    assign busy       = busy_q;
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            clk_cnt_q   <= '0;
        end else begin
            clk_cnt_q <= ((state_q == IDLE) || period_end) ? '0 : clk_cnt_q + 16'd1;

            if (accept) begin
                hold_q      <= data_in;
                hold_full_q <= 1'b1;
            end

            if (reload) begin
                shift_q     <= hold_q;
                parity_q    <= ~(^hold_q);
                hold_full_q <= 1'b0;
                bit_idx_q   <= '0;
                clk_cnt_q   <= '0;
                tx_q        <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= START_BIT;
            end else begin
                case (state_q)
                    IDLE: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START_BIT: begin
                        if (period_end) begin
                            tx_q    <= shift_q[0];
                            state_q <= DATA_BITS;
                        end
                    end
                    DATA_BITS: begin
                        if (period_end) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY_BIT;
                            end else begin
                                tx_q    <= shift_q[1];
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end
                    end
                    PARITY_BIT: begin
                        if (period_end) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP_BIT;
                        end
                    end
                    STOP_BIT: begin
                        if (period_end) begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a per-cycle line model built from frame rules plus
// a mid-bit sampling receiver that checks every delivered byte.
module tb_uart_transmitter;

    localparam int unsigned CPB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       busy;
    logic       tx;

    int unsigned total = 0;
    int unsigned bad   = 0;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: future line levels, one entry per clk cycle, plus pending byte.
    logic       line_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] pend = '0;
    bit         pend_v = 1'b0;
    bit         acc;

    function automatic void push_frame(input logic [7:0] b);
        logic v;
        for (int k = 0; k < 11; k++) begin
            if (k == 0)       v = 1'b0;
            else if (k <= 8)  v = b[k-1];
            else if (k == 9)  v = ~(^b);
            else              v = 1'b1;
            for (int c = 0; c < int'(CPB); c++) line_q.push_back(v);
        end
        sent_q.push_back(b);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            if (line_q.size() > 1 && sent_q.size() != 0) void'(sent_q.pop_back());
            line_q.delete();
            pend_v = 1'b0;
        end else begin
            acc = data_valid && !pend_v;
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && pend_v) begin
                push_frame(pend);
                pend_v = 1'b0;
            end
            if (acc) begin
                pend   = data_in;
                pend_v = 1'b1;
            end
        end
    end

    // Monitor and loopback receiver, sampled 1 time unit after each rising edge.
    bit          rx_act = 1'b0;
    int unsigned rx_cnt = 0;
    int unsigned rx_n   = 0;
    logic [10:0] rx_bits = '0;
    logic [7:0]  rx_exp;

    always @(posedge clk) begin
        #1;
        check("tx_line", tx, (line_q.size() != 0) ? line_q[0] : 1'b1);
        check("busy", busy, line_q.size() != 0);
        check("data_ready", data_ready, !pend_v && !rst);
        if (rst) begin
            rx_act = 1'b0;
        end else begin
            if (!rx_act && tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
            if (rx_act) begin
                if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] = tx;
                if (rx_cnt == 10 * CPB + CPB / 2) begin
                    rx_act = 1'b0;
                    rx_n++;
                    check("rx_start", rx_bits[0], 1'b0);
                    check("rx_parity_odd", ^rx_bits[9:1], 1'b1);
                    check("rx_stop", rx_bits[10], 1'b1);
                    if (sent_q.size() == 0) begin
                        check("rx_unexpected", rx_bits[8:1], 32'hFFFF_FFFF);
                    end else begin
                        rx_exp = sent_q.pop_front();
                        check("rx_byte", rx_bits[8:1], rx_exp);
                    end
                end
                rx_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        @(negedge clk);
        while (!data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", data_ready, 1'b1);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while ((busy || !data_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    int unsigned n_busy;
    int unsigned n_high;
    int unsigned rx_base;

    initial begin
        repeat (3) @(negedge clk);
        check("ready_in_rst", data_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", data_ready, 1'b1);

        // 0x55 from idle: one-edge latency, 22 busy cycles.
        send(8'h55);
        check("lat_pre", tx, 1'b1);
        @(posedge clk); #2;
        check("lat_tx0", tx, 1'b0);
        n_busy = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            @(posedge clk); #2;
        end
        check("busy_cycles", n_busy, 11 * CPB);

        send(8'h00);
        wait_idle();
        send(8'h07);
        wait_idle();

        // Back-to-back with a third byte offered while the holding register is full.
        rx_base = rx_n;
        send(8'hA3);
        repeat (4) @(negedge clk);
        send(8'h3C);
        check("ready_held_low", data_ready, 1'b0);
        data_in    = 8'hFF;
        data_valid = 1'b1;
        repeat (6) @(negedge clk);
        data_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("b2b_frames", rx_n - rx_base, 2);

        // Reset during data bits of 0x81 aborts the frame for good.
        rx_base = rx_n;
        send(8'h81);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_post_abort", data_ready, 1'b1);
        n_high = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx === 1'b1 && busy === 1'b0) n_high++;
        end
        check("line_stays_high", n_high, 40);
        check("abort_no_frame", rx_n - rx_base, 0);

        // Loopback of every byte value, streamed through the holding register.
        rx_base = rx_n;
        for (int i = 0; i < 256; i++) send(8'(i));
        wait_idle();
        repeat (3) @(negedge clk);
        check("loopback_count", rx_n - rx_base, 256);

        // Random bytes with random gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 30)) begin
                @(negedge clk);
                data_in = 8'($urandom);
            end
            send(8'($urandom));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("sent_drained", sent_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
